// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - opcode encoding and width default for the bitwise logic unit
package logic_pkg;

  localparam int WIDTH_DEFAULT = 64;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_core.sv
// rtl/logic_core.sv - combinational bitwise operation selected by opcode
module logic_core
  import logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NAND:   result = ~(a & b);
      OP_NOR:    result = ~(a | b);
      OP_XNOR:   result = ~(a ^ b);
      OP_PASS_A: result = a;
      OP_NOT_A:  result = ~a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - bitwise logic unit with a DEPTH-entry result FIFO and pop counter
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
  output logic [15:0]      op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [2:0]       mem_op     [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_result;
  logic [2:0]       last_op;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .a      (in_a),
    .b      (in_b),
    .op     (op_e'(in_op)),
    .result (core_result)
  );

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ((wr_ptr - rd_ptr) == PW'(DEPTH));
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_valid & out_ready;

  // When drained, the outputs show the most recently popped entry.
  assign out_result = empty ? last_result : mem_result[rd_ptr[AW-1:0]];
  assign out_op     = empty ? last_op     : mem_op[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr[AW-1:0]] <= core_result;
      mem_op[wr_ptr[AW-1:0]]     <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_result <= '0;
      last_op     <= '0;
      op_count    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        last_result <= mem_result[rd_ptr[AW-1:0]];
        last_op     <= mem_op[rd_ptr[AW-1:0]];
        op_count    <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [2:0]  out_op;
  logic [15:0] op_count;

  int n_cmp;
  int n_bad;
  int pops;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [10];
  logic [63:0] exp_q [$];

  logic_unit_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    bit done;
    logic [63:0] head;
    n_cmp = 0;
    n_bad = 0;
    pops  = 0;

    vecs[0] = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 3'd2, 64'hFFFFFFFFFFFFFFFF};
    vecs[1] = '{64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 3'd2, 64'h0000000000000000};
    vecs[2] = '{64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 3'd0, 64'hF000F000F000F000};
    vecs[3] = '{64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 3'd1, 64'hFFF0FFF0FFF0FFF0};
    vecs[4] = '{64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 3'd3, 64'h0FFF0FFF0FFF0FFF};
    vecs[5] = '{64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 3'd4, 64'h000F000F000F000F};
    vecs[6] = '{64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 3'd5, 64'hF00FF00FF00FF00F};
    vecs[7] = '{64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 3'd6, 64'h0123456789ABCDEF};
    vecs[8] = '{64'h0123456789ABCDEF, 64'h0000000000000000, 3'd7, 64'hFEDCBA9876543210};
    vecs[9] = '{64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 3'd0, 64'h8000000000000001};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_op", 64'(out_op), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requests: accept, see result one cycle later, then pop.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_op = vecs[i].op;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_result", i), out_result, vecs[i].exp);
      check($sformatf("vec%0d_op", i), 64'(out_op), 64'(vecs[i].op));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      pops++;
      check($sformatf("vec%0d_count", i), 64'(op_count), 64'(pops));
      check($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Back-pressure: NAND, NOR, NOT_A with consumer stalled.
    @(negedge clk);
    in_valid = 1'b1; in_a = 64'hF0F0F0F0F0F0F0F0; in_b = 64'hFF00FF00FF00FF00; in_op = 3'd3;
    @(posedge clk); #1;
    check("bp_ready_after1", 64'(in_ready), 64'd1);
    in_op = 3'd4;
    @(posedge clk); #1;
    check("bp_ready_after2", 64'(in_ready), 64'd0);
    in_op = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_result", out_result, 64'h0FFF0FFF0FFF0FFF);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    pops++;
    check("bp_pop1_next", out_result, 64'h000F000F000F000F);
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    pops++;
    in_valid = 1'b0;
    check("bp_third", out_result, 64'h0F0F0F0F0F0F0F0F);
    check("bp_third_op", 64'(out_op), 64'd7);
    @(posedge clk); #1;
    pops++;
    out_ready = 1'b0;
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_count", 64'(op_count), 64'(pops));

    // Simultaneous push and pop with one entry resident.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd6; in_a = 64'd100; in_b = '0;
    exp_q.push_back(64'd100);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; in_a = 64'(i + 1);
      head = exp_q.pop_front();
      exp_q.push_back(64'(i + 1));
      check($sformatf("sp%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("sp%0d_ready", i), 64'(in_ready), 64'd1);
      check($sformatf("sp%0d_head", i), out_result, head);
      @(posedge clk);
      pops++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    head = exp_q.pop_front();
    check("sp_last_head", out_result, head);
    check("sp_last_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    pops++;
    out_ready = 1'b0;
    check("sp_drained", 64'(out_valid), 64'd0);
    check("sp_count", 64'(op_count), 64'(pops));

    // Counter wrap: stream until op_count reaches FFFF.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_op = 3'd0;
    done = 1'b0;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(negedge clk);
      if (op_count == 16'hFFFF) done = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("wrap_reached", 64'(done), 64'd1);
    check("wrap_pre", 64'(op_count), 64'hFFFF);
    check("wrap_pending", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("wrap_post", 64'(op_count), 64'h0000);

    // Reset mid-operation with two entries buffered.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd1; in_a = 64'h1; in_b = 64'h2;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mr_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_count", 64'(op_count), 64'd0);
    check("mr_ready", 64'(in_ready), 64'd1);
    check("mr_result", out_result, 64'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mr_quiet%0d", i), 64'(out_valid), 64'd0);
    end
    check("mr_count_after", 64'(op_count), 64'd0);
    out_ready = 1'b0;

    // First acceptance right after a fresh reset release.
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_op = 3'd2; in_a = 64'hFF; in_b = 64'h0F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("first_accept_valid", 64'(out_valid), 64'd1);
    check("first_accept_result", out_result, 64'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
